// File: rtl/demux_p_reg.sv
// 1-to-2 demultiplexer with a one-entry holding register per output channel.
// Each channel runs a valid/ready handshake and counts delivered words.
module demux_p_reg #(
   parameter int BUS_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] i,
   input  logic                 s,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BUS_WIDTH-1:0] q0,
   output logic [BUS_WIDTH-1:0] q1,
   output logic                 q0_valid,
   output logic                 q1_valid,
   input  logic                 q0_ready,
   input  logic                 q1_ready,
   output logic [7:0]           cnt0,
   output logic [7:0]           cnt1
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } st_t;

   st_t                 r_st0;
   st_t                 r_st1;
   st_t                 w_st0_nxt;
   st_t                 w_st1_nxt;
   logic [BUS_WIDTH-1:0] r_q0;
   logic [BUS_WIDTH-1:0] r_q1;
   logic [7:0]          r_cnt0;
   logic [7:0]          r_cnt1;
   logic                w_rdy0;
   logic                w_rdy1;
   logic                w_ld0;
   logic                w_ld1;
   logic                w_dl0;
   logic                w_dl1;

   // A full channel can still take a word if it is being drained this cycle
   assign w_rdy0 = (r_st0 == EMPTY) || q0_ready;
   assign w_rdy1 = (r_st1 == EMPTY) || q1_ready;
   assign in_ready = s ? w_rdy1 : w_rdy0;

   assign w_ld0 = in_valid && !s && w_rdy0;
   assign w_ld1 = in_valid &&  s && w_rdy1;
   assign w_dl0 = (r_st0 == FULL) && q0_ready;
   assign w_dl1 = (r_st1 == FULL) && q1_ready;

   always_comb begin
      w_st0_nxt = r_st0;
      w_st1_nxt = r_st1;
      if (w_ld0) begin
         w_st0_nxt = FULL;
      end else if (w_dl0) begin
         w_st0_nxt = EMPTY;
      end
      if (w_ld1) begin
         w_st1_nxt = FULL;
      end else if (w_dl1) begin
         w_st1_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_st0  <= EMPTY;
         r_st1  <= EMPTY;
         r_q0   <= '0;
         r_q1   <= '0;
         r_cnt0 <= 8'd0;
         r_cnt1 <= 8'd0;
      end else begin
         r_st0 <= w_st0_nxt;
         r_st1 <= w_st1_nxt;
         if (w_ld0) begin
            r_q0 <= i;
         end
         if (w_ld1) begin
            r_q1 <= i;
         end
         if (w_dl0) begin
            r_cnt0 <= r_cnt0 + 8'd1;
         end
         if (w_dl1) begin
            r_cnt1 <= r_cnt1 + 8'd1;
         end
      end
   end

   assign q0       = r_q0;
   assign q1       = r_q1;
   assign q0_valid = (r_st0 == FULL);
   assign q1_valid = (r_st1 == FULL);
   assign cnt0     = r_cnt0;
   assign cnt1     = r_cnt1;

endmodule
